// File: rtl/mp_add_stream_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mp_add_stream_if : word-pair input and result-stream bundle for           |
// | mp_add_stream; in_sub only exists when MP_SUB_EN is defined.  Rev 1.0     |
// +----------------------------------------------------------------------------+
interface mp_add_stream_if #(
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [63:0]      in_a;
    logic [63:0]      in_b;
    logic             in_last;
`ifdef MP_SUB_EN
    logic             in_sub;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [63:0]      out_sum;
    logic             out_last;
    logic             out_carry;
    logic [CNT_W-1:0] out_idx;
    logic             out_err;
    logic             busy;

    modport slave (
        input  in_valid, in_a, in_b, in_last,
`ifdef MP_SUB_EN
        input  in_sub,
`endif
        output in_ready,
        output out_valid, out_sum, out_last, out_carry, out_idx, out_err, busy,
        input  out_ready
    );

    modport master (
        output in_valid, in_a, in_b, in_last,
`ifdef MP_SUB_EN
        output in_sub,
`endif
        input  in_ready,
        input  out_valid, out_sum, out_last, out_carry, out_idx, out_err, busy,
        output out_ready
    );
endinterface
`default_nettype wire

// File: rtl/mp_add_stream.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mp_add_stream : streaming LS-word-first multi-precision adder around one  |
// | adder64; MP_SUB_EN adds in_sub / subtraction.                  Rev 1.0    |
// +----------------------------------------------------------------------------+

module adder64 (
    input  wire logic [63:0] a,
    input  wire logic [63:0] b,
    input  wire logic        cin,
    output logic      [63:0] sum,
    output logic             cout,
    output logic             p_g,
    output logic             g_g
);
    logic [63:0] p;
    logic [63:0] g;
    logic [63:0] c;
    logic [15:0] gp;
    logic [15:0] gg;
    logic [16:0] gc;

    assign p = a ^ b;
    assign g = a & b;

    generate
        for (genvar j = 0; j < 16; j++) begin : g_grp
            assign gp[j]     = &p[4*j +: 4];
            assign gg[j]     = g[4*j+3]
                             | (p[4*j+3] & g[4*j+2])
                             | (p[4*j+3] & p[4*j+2] & g[4*j+1])
                             | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
            assign c[4*j]    = gc[j];
            assign c[4*j+1]  = g[4*j] | (p[4*j] & gc[j]);
            assign c[4*j+2]  = g[4*j+1] | (p[4*j+1] & g[4*j])
                             | (p[4*j+1] & p[4*j] & gc[j]);
            assign c[4*j+3]  = g[4*j+2] | (p[4*j+2] & g[4*j+1])
                             | (p[4*j+2] & p[4*j+1] & g[4*j])
                             | (p[4*j+2] & p[4*j+1] & p[4*j] & gc[j]);
        end
    endgenerate

    // Second level: group carries resolved from group propagate/generate.
    always_comb begin
        logic gz;
        gc[0] = cin;
        gz    = 1'b0;
        for (int j = 0; j < 16; j++) begin
            gc[j+1] = gg[j] | (gp[j] & gc[j]);
            gz      = gg[j] | (gp[j] & gz);
        end
        g_g = gz;
    end

    assign sum  = p ^ c;
    assign cout = gc[16];
    assign p_g  = &gp;
endmodule

module mp_add_stream #(
    parameter int CNT_W = 8
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    mp_add_stream_if.slave  bus
);
    localparam logic [CNT_W-1:0] IDX_MAX = '1;

    typedef enum logic [0:0] {
        FIRST = 1'b0,
        MID   = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic             carry_q, carry_d;
    logic [CNT_W-1:0] idx_q, idx_d;
    logic             out_valid_q, out_valid_d;
    logic [63:0]      out_sum_q, out_sum_d;
    logic             out_last_q, out_last_d;
    logic             out_carry_q, out_carry_d;
    logic [CNT_W-1:0] out_idx_q, out_idx_d;
    logic             out_err_q, out_err_d;

    logic             xfer;
    logic             ovf;
    logic             sub_eff;
    logic             cin;
    logic [63:0]      b_eff;
    logic [63:0]      sum;
    logic             cout;
    logic             unused_pg;
    logic             unused_gg;

`ifdef MP_SUB_EN
    logic             sub_q, sub_d;
    assign sub_eff = (state_q == FIRST) ? bus.in_sub : sub_q;
`else
    assign sub_eff = 1'b0;
`endif

    assign xfer  = bus.in_valid && bus.in_ready;
    assign ovf   = (idx_q == IDX_MAX) && !bus.in_last;
    // Subtraction is A + ~B + 1; the +1 enters as the first-beat carry-in.
    assign cin   = (state_q == FIRST) ? sub_eff : carry_q;
    assign b_eff = sub_eff ? ~bus.in_b : bus.in_b;

    adder64 u_add (
        .a    (bus.in_a),
        .b    (b_eff),
        .cin  (cin),
        .sum  (sum),
        .cout (cout),
        .p_g  (unused_pg),
        .g_g  (unused_gg)
    );

    always_comb begin
        state_d     = state_q;
        carry_d     = carry_q;
        idx_d       = idx_q;
        out_valid_d = out_valid_q;
        out_sum_d   = out_sum_q;
        out_last_d  = out_last_q;
        out_carry_d = out_carry_q;
        out_idx_d   = out_idx_q;
        out_err_d   = out_err_q;
`ifdef MP_SUB_EN
        sub_d       = sub_q;
`endif
        if (xfer) begin
            out_valid_d = 1'b1;
            out_sum_d   = sum;
            out_idx_d   = idx_q;
            out_last_d  = bus.in_last || ovf;
            out_carry_d = (bus.in_last || ovf) ? cout : 1'b0;
            out_err_d   = ovf;
            if (state_q == FIRST) begin
`ifdef MP_SUB_EN
                sub_d = bus.in_sub;
`endif
                if (bus.in_last) begin
                    carry_d = 1'b0;
                    idx_d   = '0;
                end else begin
                    state_d = MID;
                    carry_d = cout;
                    idx_d   = CNT_W'(1);
                end
            end else if (bus.in_last || ovf) begin
                // Overflow closes the packet; the next word opens a new one.
                state_d = FIRST;
                carry_d = 1'b0;
                idx_d   = '0;
            end else begin
                carry_d = cout;
                idx_d   = idx_q + CNT_W'(1);
            end
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= FIRST;
            carry_q     <= 1'b0;
            idx_q       <= '0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_last_q  <= 1'b0;
            out_carry_q <= 1'b0;
            out_idx_q   <= '0;
            out_err_q   <= 1'b0;
`ifdef MP_SUB_EN
            sub_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            carry_q     <= carry_d;
            idx_q       <= idx_d;
            out_valid_q <= out_valid_d;
            out_sum_q   <= out_sum_d;
            out_last_q  <= out_last_d;
            out_carry_q <= out_carry_d;
            out_idx_q   <= out_idx_d;
            out_err_q   <= out_err_d;
`ifdef MP_SUB_EN
            sub_q       <= sub_d;
`endif
        end
    end

    assign bus.in_ready  = !out_valid_q || bus.out_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_sum   = out_sum_q;
    assign bus.out_last  = out_last_q;
    assign bus.out_carry = out_carry_q;
    assign bus.out_idx   = out_idx_q;
    assign bus.out_err   = out_err_q;
    assign bus.busy      = (state_q == MID);
endmodule
`default_nettype wire

// File: tb/tb_mp_add_stream.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_mp_add_stream : directed scoreboard bench for mp_add_stream (CNT_W=2); |
// | exercises the in_sub path when MP_SUB_EN is defined.           Rev 1.0    |
// +----------------------------------------------------------------------------+
module tb_mp_add_stream;
    localparam int          CW   = 2;
    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    typedef struct packed {
        logic [63:0]   sum;
        logic          last;
        logic          carry;
        logic [CW-1:0] idx;
        logic          err;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_asrt;
    int   n_fail;
    exp_t sb[$];

    logic          m_first;
    logic          m_carry;
    logic [CW-1:0] m_idx;
    logic          m_sub;

    mp_add_stream_if #(.CNT_W(CW)) bus ();

    mp_add_stream #(.CNT_W(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_first = 1'b1;
        m_carry = 1'b0;
        m_idx   = '0;
        m_sub   = 1'b0;
    endtask

    // Reference word model: expected output for one accepted beat.
    task automatic model_push(input logic [63:0] a, input logic [63:0] b,
                              input logic last, input logic sub);
        logic        s_eff;
        logic [64:0] full;
        logic        ovf;
        exp_t        e;
        s_eff   = m_first ? sub : m_sub;
        full    = {1'b0, a} + {1'b0, (s_eff ? ~b : b)} + {64'd0, (m_first ? s_eff : m_carry)};
        ovf     = (m_idx == {CW{1'b1}}) && !last;
        e.sum   = full[63:0];
        e.last  = last || ovf;
        e.carry = (last || ovf) ? full[64] : 1'b0;
        e.idx   = m_idx;
        e.err   = ovf;
        sb.push_back(e);
        if (m_first) begin
            m_sub = sub;
            if (!last) begin
                m_first = 1'b0;
                m_carry = full[64];
                m_idx   = 1;
            end
        end else if (last || ovf) begin
            m_first = 1'b1;
            m_carry = 1'b0;
            m_idx   = '0;
        end else begin
            m_carry = full[64];
            m_idx   = m_idx + 1'b1;
        end
    endtask

    // Presents one word pair and returns #1 after the edge that accepted it.
    task automatic send(input logic [63:0] a, input logic [63:0] b,
                        input logic last, input logic sub);
        int   cnt;
        logic s;
        s            = sub;
`ifdef MP_SUB_EN
        bus.in_sub   = s;
`else
        s            = 1'b0;
`endif
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_last  = last;
        bus.in_valid = 1'b1;
        cnt          = 0;
        @(negedge clk);
        while (!bus.in_ready && cnt < 200) begin
            cnt++;
            @(negedge clk);
        end
        if (cnt >= 200) chk("send_timeout_in_ready", {63'd0, bus.in_ready}, 64'd1);
        @(posedge clk);
        model_push(a, b, last, s);
        #1;
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
        bus.in_a     = '0;
        bus.in_b     = '0;
        bus.in_last  = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            chk("sb_nonempty", {63'd0, (sb.size() != 0)}, 64'd1);
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_sum",   bus.out_sum,              e.sum);
                chk("sb_last",  {63'd0, bus.out_last},    {63'd0, e.last});
                chk("sb_carry", {63'd0, bus.out_carry},   {63'd0, e.carry});
                chk("sb_idx",   {{(64-CW){1'b0}}, bus.out_idx}, {{(64-CW){1'b0}}, e.idx});
                chk("sb_err",   {63'd0, bus.out_err},     {63'd0, e.err});
            end
        end
    end

    initial begin
        logic [63:0]   snap_sum;
        logic [CW-1:0] snap_idx;
        logic          snap_last;
        n_asrt = 0;
        n_fail = 0;
        model_reset();
        rst_n         = 1'b0;
        bus.out_ready = 1'b1;
`ifdef MP_SUB_EN
        bus.in_sub    = 1'b0;
`endif
        idle();
        #12;
        chk("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("rst_out_sum",   bus.out_sum, 64'd0);
        chk("rst_out_last",  {63'd0, bus.out_last}, 64'd0);
        chk("rst_out_carry", {63'd0, bus.out_carry}, 64'd0);
        chk("rst_out_idx",   {{(64-CW){1'b0}}, bus.out_idx}, 64'd0);
        chk("rst_out_err",   {63'd0, bus.out_err}, 64'd0);
        chk("rst_busy",      {63'd0, bus.busy}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single-word packet with carry out, one-cycle latency.
        chk("t1_pre_valid", {63'd0, bus.out_valid}, 64'd0);
        send(ONES, 64'd1, 1'b1, 1'b0);
        chk("t1_valid", {63'd0, bus.out_valid}, 64'd1);
        chk("t1_sum",   bus.out_sum, 64'd0);
        chk("t1_carry", {63'd0, bus.out_carry}, 64'd1);
        chk("t1_last",  {63'd0, bus.out_last}, 64'd1);
        chk("t1_idx",   {{(64-CW){1'b0}}, bus.out_idx}, 64'd0);
        idle();
        @(posedge clk);
        #1;

        // Three-word packet; busy across the packet.
        send(ONES, 64'd1, 1'b0, 1'b0);
        chk("t2_busy0", {63'd0, bus.busy}, 64'd1);
        send(ONES, 64'd0, 1'b0, 1'b0);
        chk("t2_busy1", {63'd0, bus.busy}, 64'd1);
        send(64'd0, 64'd0, 1'b1, 1'b0);
        chk("t2_busy2", {63'd0, bus.busy}, 64'd0);
        chk("t2_sum2",  bus.out_sum, 64'd1);
        chk("t2_carry", {63'd0, bus.out_carry}, 64'd0);
        idle();
        @(posedge clk);
        #1;

        // Back-to-back packets: carry from packet 1 must not reach packet 2.
        send(ONES, 64'd1, 1'b0, 1'b0);
        send(ONES, ONES, 1'b1, 1'b0);
        send(64'd2, 64'd3, 1'b1, 1'b0);
        chk("t3_sum5",   bus.out_sum, 64'd5);
        chk("t3_carry0", {63'd0, bus.out_carry}, 64'd0);
        idle();
        @(posedge clk);
        #1;

        // Downstream stall for 4 cycles mid-packet.
        send(ONES, ONES, 1'b0, 1'b0);
        snap_sum      = bus.out_sum;
        snap_idx      = bus.out_idx;
        snap_last     = bus.out_last;
        bus.out_ready = 1'b0;
        bus.in_a      = 64'd1;
        bus.in_b      = 64'd2;
        bus.in_last   = 1'b0;
        bus.in_valid  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t4_in_ready", {63'd0, bus.in_ready}, 64'd0);
            chk("t4_valid",    {63'd0, bus.out_valid}, 64'd1);
            chk("t4_sum_hold", bus.out_sum, snap_sum);
            chk("t4_idx_hold", {{(64-CW){1'b0}}, bus.out_idx}, {{(64-CW){1'b0}}, snap_idx});
            chk("t4_last_hold", {63'd0, bus.out_last}, {63'd0, snap_last});
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        send(64'd1, 64'd2, 1'b0, 1'b0);
        send(64'd3, 64'd4, 1'b1, 1'b0);
        chk("t4_sum_last", bus.out_sum, 64'd7);
        idle();
        @(posedge clk);
        #1;

        // Index overflow with CNT_W=2: word 3 closes the packet with err.
        send(ONES, 64'd1, 1'b0, 1'b0);
        send(ONES, 64'd1, 1'b0, 1'b0);
        send(ONES, 64'd1, 1'b0, 1'b0);
        send(ONES, 64'd1, 1'b0, 1'b0);
        chk("t5_ovf_idx",  {{(64-CW){1'b0}}, bus.out_idx}, 64'd3);
        chk("t5_ovf_last", {63'd0, bus.out_last}, 64'd1);
        chk("t5_ovf_err",  {63'd0, bus.out_err}, 64'd1);
        chk("t5_ovf_busy", {63'd0, bus.busy}, 64'd0);
        send(ONES, 64'd1, 1'b0, 1'b0);
        chk("t5_new_idx", {{(64-CW){1'b0}}, bus.out_idx}, 64'd0);
        chk("t5_new_err", {63'd0, bus.out_err}, 64'd0);
        chk("t5_new_sum", bus.out_sum, 64'd0);
        send(64'd0, 64'd0, 1'b1, 1'b0);
        idle();
        @(posedge clk);
        #1;

        // Asynchronous reset mid-packet drops pending output and carry.
        send(ONES, 64'd1, 1'b0, 1'b0);
        idle();
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("t6_sum",   bus.out_sum, 64'd0);
        chk("t6_last",  {63'd0, bus.out_last}, 64'd0);
        chk("t6_idx",   {{(64-CW){1'b0}}, bus.out_idx}, 64'd0);
        chk("t6_busy",  {63'd0, bus.busy}, 64'd0);
        sb.delete();
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send(64'd5, 64'd7, 1'b1, 1'b1);
`ifdef MP_SUB_EN
        chk("t6_sub_sum",   bus.out_sum, 64'hFFFF_FFFF_FFFF_FFFE);
        chk("t6_sub_carry", {63'd0, bus.out_carry}, 64'd0);
`else
        chk("t6_add_sum",   bus.out_sum, 64'd12);
        chk("t6_add_carry", {63'd0, bus.out_carry}, 64'd0);
`endif
        idle();
        repeat (3) @(posedge clk);
        #1;
        chk("sb_drained", {32'd0, sb.size()}, 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/mp_add_stream.md
Name: mp_add_stream

Overview:
- Streaming multi-precision adder. Accepts operands as a sequence of 64-bit word pairs, least-significant word first, and adds them one word per cycle.
- Chains the carry between words in a register; the per-word add is done by one instance of the team's 64-bit carry-lookahead adder (adder64).
- Sits directly upstream of adder64: it feeds that adder, consumes its sum and carry, and presents a registered result stream to downstream logic (bignum/crypto datapath).

Parameters:
- CNT_W, 8, width of the word-index counter; max packet length is 2^CNT_W words.

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  input word pair valid
- in_ready  output  1  block can accept a word pair
- in_a  input  64  operand A word
- in_b  input  64  operand B word
- in_last  input  1  final (most-significant) word of the packet
- in_sub  input  1  subtract select, sampled on the first beat (present only with MP_SUB_EN)
- out_valid  output  1  result word valid
- out_ready  input  1  downstream accepts the result word
- out_sum  output  64  result word
- out_last  output  1  final result word of the packet
- out_carry  output  1  packet carry-out, meaningful only when out_last=1, else 0
- out_idx  output  CNT_W  word index within the packet (0 = LS word)
- out_err  output  1  packet truncated by index overflow
- busy  output  1  packet in progress (state MID)

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values: out_valid=0, out_sum=0, out_last=0, out_carry=0, out_idx=0, out_err=0, busy=0. Internally: state=FIRST, carry_q=0, idx_q=0, sub_q=0.
- Handshake:
  - Transfer when in_valid && in_ready.
  - in_ready = !out_valid || out_ready (single registered stage, full throughput).
  - While out_valid && !out_ready, all out_* hold stable.
  - in_* are don't-care when in_valid=0.
- Datapath: adder64.a=in_a; adder64.b=in_b; adder64.cin = (state==FIRST) ? 0 : carry_q. The adder64 p_g and g_g outputs are unused.
- Latency: 1 cycle from input transfer to out_valid. Output register loads on transfer:
  - out_sum = adder sum
  - out_idx = idx_q
  - out_last = in_last || overflow
  - out_carry = out_last ? adder cout : 0
  - out_err = overflow
- out_valid: set on transfer. Cleared on out_ready when there is no new transfer in the same cycle. Simultaneous accept + new transfer keeps it at 1 with the new data.
- State machine (FIRST, MID):
  - FIRST, transfer with !in_last -> MID; carry_q <= cout; idx_q <= 1.
  - FIRST, transfer with in_last -> FIRST (single-word packet); idx_q stays 0.
  - MID, transfer with !in_last and !overflow -> MID; carry_q <= cout; idx_q++.
  - MID, transfer with in_last or overflow -> FIRST; carry_q <= 0; idx_q <= 0.
  - No transfer -> hold all state.
- busy = (state==MID).
- Overflow: defined as idx_q == 2^CNT_W-1 && !in_last on a transfer.
  - That beat is emitted with out_last=1 and out_err=1; state returns to FIRST.
  - Subsequent words start a new packet; no wrap into index 0 mid-packet.
- Reset mid-packet: everything clears immediately and asynchronously. The next accepted word is treated as the first word of a new packet, and any pending output is dropped.

Optional Feature:
- MP_SUB_EN: adds the in_sub port and subtraction.
- With the macro defined:
  - sub_q is captured from in_sub on each FIRST-state transfer and held for the whole packet.
  - Effective subtract = in_sub on the FIRST beat, sub_q thereafter.
  - When subtracting: adder64.b = ~in_b, and the FIRST-beat cin = 1.
  - out_carry on the last word = 1 means no borrow (A >= B).
- Without the macro: in_sub and sub_q are absent and the block is add-only, exactly as in Behaviour.

Test Plan:
- Single word, A=0xFFFF_FFFF_FFFF_FFFF, B=1, last=1 -> out_sum=0, out_carry=1, out_last=1, out_idx=0, 1-cycle latency.
- 3-word packet: A words {FFFF..FF, FFFF..FF, 0}, B words {1, 0, 0} -> sums {0, 0, 1}, idx {0, 1, 2}, out_carry=0 on the last word, busy high between beats.
- Back-to-back packets at full rate with out_ready=1: a carry left in carry_q from packet 1 must not leak into word 0 of packet 2 (2+3=5).
- out_ready held low for 4 cycles mid-packet -> in_ready=0, outputs stable, no word lost or duplicated; the sequence resumes correctly.
- CNT_W=2, 5 words with no in_last -> word idx 3 emitted with out_last=1 and out_err=1; word 5 emitted with idx 0, err 0, cin 0.
- rst_n asserted after word 1 of 3 -> all outputs 0 asynchronously; the next word is treated as a first word (cin=0). With MP_SUB_EN, 5-7 in one word -> out_sum=0xFFFF_FFFF_FFFF_FFFE, out_carry=0.
